// File: rtl/serial_output_neuron.sv
// Sequential output-layer neuron: captures one activation vector, adds one saturating
// weighted term per clock, then presents a thresholded decision and the signed sum.
module serial_output_neuron #(
  parameter int N_IN      = 5,
  parameter int W_WIDTH   = 10,
  parameter int ACC_WIDTH = 24,
  parameter int THRESH    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN-1:0]           in_bits,
  input  logic [N_IN*W_WIDTH-1:0]   weights,
  input  logic [W_WIDTH-1:0]        bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_bit,
  output logic [ACC_WIDTH-1:0]      out_sum,
  output logic                      busy
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_IN - 1);
  localparam logic signed [ACC_WIDTH-1:0] TH   = ACC_WIDTH'(THRESH);
  localparam logic signed [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                      state, state_nx;
  logic [N_IN-1:0]             bits_q;
  logic [N_IN*W_WIDTH-1:0]     w_q;
  logic [IW-1:0]               idx;
  logic signed [ACC_WIDTH-1:0] acc, acc_add;
  logic signed [W_WIDTH-1:0]   wsel;
  logic                        bsel;
  logic signed [ACC_WIDTH:0]   sum_x;

  // Mux by explicit compare so idx never addresses past the last lane.
  always_comb begin
    wsel = '0;
    bsel = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx == IW'(i)) begin
        wsel = w_q[i*W_WIDTH +: W_WIDTH];
        bsel = bits_q[i];
      end
    end
  end

  // One extra bit catches overflow; clamp instead of wrapping.
  always_comb begin
    sum_x = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(wsel);
    if (sum_x[ACC_WIDTH] != sum_x[ACC_WIDTH-1])
      acc_add = sum_x[ACC_WIDTH] ? SMIN : SMAX;
    else
      acc_add = sum_x[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_bit   = 1'b0;
    out_sum   = acc;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ACC;
      end
      ACC: begin
        busy = 1'b1;
        if (idx == LAST) state_nx = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_bit   = (acc >= TH);
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q <= '0;
      w_q    <= '0;
      idx    <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          bits_q <= in_bits;
          w_q    <= weights;
          acc    <= ACC_WIDTH'($signed(bias));
          idx    <= '0;
        end
        ACC: begin
          if (bsel) acc <= acc_add;
          if (idx != LAST) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
